// File: rtl/fetch_if.sv
// Fetch-side bundle between the program-counter sequencer and the MIPS pipeline.
// master = pipeline/hazard side, slave = fetch_sequencer.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic [31:0] exc_pc;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        epc_we;
  logic [31:0] epc;
  logic        irq_ack;
  logic        kernel;
  logic [1:0]  state_dbg;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exc, exc_pc, irq,
    input  pc, pc_plus4, fetch_valid, flush_ifid, flush_idex,
           epc_we, epc, irq_ack, kernel, state_dbg
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exc, exc_pc, irq,
    output pc, pc_plus4, fetch_valid, flush_ifid, flush_idex,
           epc_we, epc, irq_ack, kernel, state_dbg
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner: boot delay, sequential/redirect/stall/trap next-PC
// selection, flush strobes, EPC write and interrupt acknowledge.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] RESET_VEC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC     = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC     = 32'h8000_0008
) (
  input logic    clk,
  input logic    reset,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;

  logic        fetch_valid, flush_ifid, flush_idex, epc_we, irq_ack;
  logic [31:0] epc;
  logic        redir;
  logic [31:0] redir_target;

  // Jump and branch targets keep the current mode bit; jr uses its target as given.
  always_comb begin
    redir = bus.jr | bus.jump | bus.branch_taken;
    if (bus.jr)
      redir_target = bus.jr_target;
    else if (bus.jump)
      redir_target = {pc_q[31], bus.jump_target[30:0]};
    else
      redir_target = {pc_q[31], bus.branch_target[30:0]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    pending_d   = pending_q | bus.irq;
    fetch_valid = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    epc_we      = 1'b0;
    epc         = 32'h0;
    irq_ack     = 1'b0;
    // Strobes are gated by reset so a trap in the reset cycle never writes EPC.
    if (reset) begin
      case (state_q)
        ST_BOOT: begin
          if (cnt_q == 4'(BOOT_CYCLES - 1))
            state_d = ST_RUN;
          else
            cnt_d = cnt_q + 4'd1;
        end
        ST_RUN: begin
          fetch_valid = 1'b1;
          if (bus.exc) begin
            pc_d       = EXC_VEC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            epc_we     = 1'b1;
            epc        = bus.exc_pc + 32'd4;
            state_d    = ST_TRAP;
          end else if (bus.stall) begin
            pc_d = pc_q;
          end else if (pending_q && !pc_q[31]) begin
            pc_d       = IRQ_VEC;
            irq_ack    = 1'b1;
            epc_we     = 1'b1;
            epc        = redir ? redir_target : (pc_q + 32'd4);
            flush_ifid = redir;
            pending_d  = 1'b0;
            state_d    = ST_TRAP;
          end else if (redir) begin
            pc_d       = redir_target;
            flush_ifid = 1'b1;
          end else begin
            pc_d = {pc_q[31], pc_q[30:0] + 31'd4};
          end
        end
        ST_TRAP: state_d = ST_RUN;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      cnt_q     <= 4'd0;
      pc_q      <= RESET_VEC;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.kernel      = pc_q[31];
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.epc_we      = epc_we;
  assign bus.epc         = epc;
  assign bus.irq_ack     = irq_ack;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table for fetch_sequencer plus hand-written boot-length and
// held-interrupt sequences.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_sequencer #(.BOOT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n, stall, irq, exc;
    logic [31:0] exc_pc;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic        e_fv, e_fi, e_fx, e_we;
    logic [31:0] e_epc;
    logic        e_ack;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(
    logic rst_n, logic stall, logic irq, logic exc, logic [31:0] exc_pc,
    logic br, logic [31:0] bt, logic j, logic [31:0] jt, logic jr, logic [31:0] jrt,
    logic [31:0] e_pc, logic e_fv, logic e_fi, logic e_fx, logic e_we,
    logic [31:0] e_epc, logic e_ack);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.irq = irq; v.exc = exc; v.exc_pc = exc_pc;
    v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.jr = jr; v.jrt = jrt;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_fi = e_fi; v.e_fx = e_fx; v.e_we = e_we;
    v.e_epc = e_epc; v.e_ack = e_ack;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset             = v.rst_n;
    bus.stall         = v.stall;
    bus.irq           = v.irq;
    bus.exc           = v.exc;
    bus.exc_pc        = v.exc_pc;
    bus.branch_taken  = v.br;
    bus.branch_target = v.bt;
    bus.jump          = v.j;
    bus.jump_target   = v.jt;
    bus.jr            = v.jr;
    bus.jr_target     = v.jrt;
  endtask

  task automatic apply(input vec_t v, input int row);
    logic [31:0] e_pc;
    drive(v);
    exp_q.push_back(v.e_pc);
    @(negedge clk);
    e_pc = exp_q.pop_front();
    check("pc",          row, bus.pc, e_pc);
    check("pc_plus4",    row, bus.pc_plus4, e_pc + 32'd4);
    check("kernel",      row, 32'(bus.kernel), 32'(e_pc[31]));
    check("fetch_valid", row, 32'(bus.fetch_valid), 32'(v.e_fv));
    check("flush_ifid",  row, 32'(bus.flush_ifid), 32'(v.e_fi));
    check("flush_idex",  row, 32'(bus.flush_idex), 32'(v.e_fx));
    check("epc_we",      row, 32'(bus.epc_we), 32'(v.e_we));
    check("irq_ack",     row, 32'(bus.irq_ack), 32'(v.e_ack));
    if (v.e_we) check("epc", row, bus.epc, v.e_epc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    int   n;
    idle = mk(1,0,0,0,0, 0,0, 0,0, 0,0, 0,0,0,0,0,0,0);
    drive(idle);
    reset = 1'b0;
    @(posedge clk);
    #1;

    //            rst st irq exc exc_pc     br bt            j jt            jr jrt           e_pc          fv fi fx we e_epc        ack
    vecs.push_back(mk(0,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000000, 0,0,0,0,0,           0)); // 0 reset
    vecs.push_back(mk(0,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000000, 0,0,0,0,0,           0)); // 1
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000000, 0,0,0,0,0,           0)); // 2 boot
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000000, 0,0,0,0,0,           0)); // 3 boot
    vecs.push_back(mk(1,0,0,0,0,            0,0,            1,32'h0000000C, 0,0,            32'h80000000, 1,1,0,0,0,           0)); // 4 jump
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h8000000C, 1,0,0,0,0,           0)); // 5
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'h00000020, 32'h80000010, 1,1,0,0,0,           0)); // 6 jr to user
    vecs.push_back(mk(1,1,1,0,0,            0,0,            0,0,            0,0,            32'h00000020, 1,0,0,0,0,           0)); // 7 stall+irq
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h00000020, 1,0,0,1,32'h00000024,1)); // 8 irq taken
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            IRQ_VEC,      0,0,0,0,0,           0)); // 9 trap
    vecs.push_back(mk(1,0,1,0,0,            0,0,            0,0,            0,0,            IRQ_VEC,      1,0,0,0,0,           0)); // 10 irq in kernel
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'h00000040, 32'h80000008, 1,1,0,0,0,           0)); // 11 eret
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h00000040, 1,0,0,1,32'h00000044,1)); // 12 ack
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            IRQ_VEC,      0,0,0,0,0,           0)); // 13 trap
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'h00000010, IRQ_VEC,      1,1,0,0,0,           0)); // 14
    vecs.push_back(mk(1,0,1,1,32'h00000014, 0,0,            0,0,            0,0,            32'h00000010, 1,1,1,1,32'h00000018,0)); // 15 exc+irq
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000008, 0,0,0,0,0,           0)); // 16 trap
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'h00000030, 32'h80000008, 1,1,0,0,0,           0)); // 17 eret
    vecs.push_back(mk(1,0,0,0,0,            1,32'h00000100, 0,0,            0,0,            32'h00000030, 1,1,0,1,32'h00000100,1)); // 18 irq w/ branch
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            IRQ_VEC,      0,0,0,0,0,           0)); // 19 trap
    vecs.push_back(mk(1,0,0,0,0,            1,32'h00000050, 1,32'h00000200, 1,32'h00000100, IRQ_VEC,      1,1,0,0,0,           0)); // 20 jr wins
    vecs.push_back(mk(1,0,0,0,0,            1,32'h80000060, 1,32'h00000200, 0,0,            32'h00000100, 1,1,0,0,0,           0)); // 21 jump wins
    vecs.push_back(mk(1,1,0,0,0,            1,32'h00000400, 0,0,            0,0,            32'h00000200, 1,0,0,0,0,           0)); // 22 stall beats branch
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h00000200, 1,0,0,0,0,           0)); // 23
    vecs.push_back(mk(1,0,0,0,0,            1,32'h80000300, 0,0,            0,0,            32'h00000204, 1,1,0,0,0,           0)); // 24 branch keeps mode
    vecs.push_back(mk(1,0,1,0,0,            0,0,            0,0,            0,0,            32'h00000300, 1,0,0,0,0,           0)); // 25 irq pulse
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h00000304, 1,0,0,1,32'h00000308,1)); // 26 ack
    vecs.push_back(mk(0,0,0,0,0,            0,0,            0,0,            0,0,            IRQ_VEC,      0,0,0,0,0,           0)); // 27 reset mid-trap
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            RESET_VEC,    0,0,0,0,0,           0)); // 28 boot
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            RESET_VEC,    0,0,0,0,0,           0)); // 29 boot
    vecs.push_back(mk(0,0,0,1,32'h00000070, 0,0,            0,0,            0,0,            RESET_VEC,    0,0,0,0,0,           0)); // 30 reset kills exc
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            RESET_VEC,    0,0,0,0,0,           0)); // 31 boot
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            RESET_VEC,    0,0,0,0,0,           0)); // 32 boot
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'h7FFFFFFC, RESET_VEC,    1,1,0,0,0,           0)); // 33
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h7FFFFFFC, 1,0,0,0,0,           0)); // 34 user wrap
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            1,32'hFFFFFFFC, 32'h00000000, 1,1,0,0,0,           0)); // 35
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'hFFFFFFFC, 1,0,0,0,0,           0)); // 36 kernel wrap
    vecs.push_back(mk(1,0,0,0,0,            0,0,            0,0,            0,0,            32'h80000000, 1,0,0,0,0,           0)); // 37

    foreach (vecs[i]) apply(vecs[i], i);

    // Boot length measured from reset release, bounded.
    drive(idle);
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.fetch_valid) break;
      n++;
      @(posedge clk); #1;
    end
    check("boot_len", 100, 32'(n), 32'd2);
    check("boot_pc", 100, bus.pc, RESET_VEC);
    @(posedge clk); #1;

    // Level interrupt held in kernel mode is never acknowledged.
    bus.irq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("kernel_no_ack", 101 + k, 32'(bus.irq_ack), 32'd0);
      @(posedge clk); #1;
    end
    bus.irq       = 1'b0;
    bus.jr        = 1'b1;
    bus.jr_target = 32'h00000080;
    @(negedge clk);
    check("eret_flush", 105, 32'(bus.flush_ifid), 32'd1);
    check("eret_no_ack", 105, 32'(bus.irq_ack), 32'd0);
    @(posedge clk); #1;
    bus.jr = 1'b0;
    @(negedge clk);
    check("held_ack", 106, 32'(bus.irq_ack), 32'd1);
    check("held_epc", 106, bus.epc, 32'h00000084);
    check("held_pc", 106, bus.pc, 32'h00000080);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_trap_fv", 107, 32'(bus.fetch_valid), 32'd0);
    check("held_trap_pc", 107, bus.pc, IRQ_VEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
